// File: rtl/dp_ram_fifo_ctrl.sv
// FIFO controller driving the address/write ports of a dp_ram.
// Optional FIFO_STATS_EN adds high_water and stall_cycles outputs.
module dp_ram_fifo_ctrl #(
  parameter int ADDRESS_WIDTH     = 12,
  parameter int DATA_WIDTH        = 8,
  parameter int ALMOST_FULL_LEVEL = 2**ADDRESS_WIDTH-4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [DATA_WIDTH-1:0]    s_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [DATA_WIDTH-1:0]    m_data,
  output logic [ADDRESS_WIDTH:0]   count,
  output logic                     almost_full,
  output logic                     ram_write_en,
  output logic [ADDRESS_WIDTH-1:0] ram_write_address,
  output logic [DATA_WIDTH-1:0]    ram_write_data,
  output logic [ADDRESS_WIDTH-1:0] ram_read_address,
  input  logic [DATA_WIDTH-1:0]    ram_read_data
`ifdef FIFO_STATS_EN
  ,
  output logic [ADDRESS_WIDTH:0]   high_water,
  output logic [15:0]              stall_cycles
`endif
);

  localparam int PW = ADDRESS_WIDTH + 1;
  localparam logic [ADDRESS_WIDTH:0] DEPTH = PW'(2**ADDRESS_WIDTH);
  localparam logic [ADDRESS_WIDTH:0] AF_LVL = PW'(ALMOST_FULL_LEVEL);

  logic [ADDRESS_WIDTH:0] wr_ptr, wr_ptr_nxt;
  logic [ADDRESS_WIDTH:0] rd_ptr, rd_ptr_nxt;
  logic [ADDRESS_WIDTH:0] count_nxt;
  logic full, empty, push, pop;

  assign full    = (count == DEPTH);
  assign empty   = (count == '0);
  assign s_ready = !full;
  assign m_valid = !empty;
  assign push    = s_valid & s_ready;
  assign pop     = m_valid & m_ready;

  assign ram_write_en      = push & !flush;
  assign ram_write_address = wr_ptr[ADDRESS_WIDTH-1:0];
  assign ram_write_data    = s_data;
  assign ram_read_address  = rd_ptr_nxt[ADDRESS_WIDTH-1:0];
  assign m_data            = ram_read_data;

  // Next pointers and occupancy; flush overrides any transfer.
  always_comb begin
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    count_nxt  = count;
    if (flush) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
      count_nxt  = '0;
    end else begin
      if (push) wr_ptr_nxt = wr_ptr + 1'b1;
      if (pop)  rd_ptr_nxt = rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count_nxt = count + 1'b1;
        2'b01:   count_nxt = count - 1'b1;
        default: count_nxt = count;
      endcase
    end
  end

  // State registers; almost_full follows next-count with no lag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      almost_full <= 1'b0;
    end else begin
      wr_ptr      <= wr_ptr_nxt;
      rd_ptr      <= rd_ptr_nxt;
      count       <= count_nxt;
      almost_full <= (count_nxt >= AF_LVL);
    end
  end

`ifdef FIFO_STATS_EN
  // Peak occupancy and saturating producer-stall counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      high_water   <= '0;
      stall_cycles <= '0;
    end else if (flush) begin
      high_water   <= '0;
      stall_cycles <= '0;
    end else begin
      if (count_nxt > high_water)
        high_water <= count_nxt;
      if (s_valid && !s_ready && !(&stall_cycles))
        stall_cycles <= stall_cycles + 16'd1;
    end
  end
`endif

endmodule
